// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants and types for the elastic pipeline-stage register.
package pipe_skid_stage_pkg;

    // Canonical RV NOP (addi x0, x0, 0), used as the bubble for instruction-carrying stages.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Stage occupancy; the encoding doubles as the count_o value.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the skid stage: payload flop plus valid flop.
module pipe_entry
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Reset and clear both park the slot on the bubble; clear wins over load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a one-entry skid buffer and flush.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic [DATA_W-1:0] main_d;
    logic              in_fire, out_fire;
    occ_e              occ;

    // Skid can only hold data while main is also valid, so this is the occupancy.
    assign occ = occ_e'({skid_v, main_v & ~skid_v});

    assign in_ready_o  = ~skid_v;
    assign out_valid_o = main_v;
    assign out_data_o  = main_data;
    assign count_o     = occ;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Steer loads/clears of the two slots from occupancy and the two handshakes.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data_i;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush_i) begin
            // Offered payload is dropped; an output fire counts as consumed downstream.
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (occ)
                OccEmpty: main_load = in_fire;
                OccOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                    end
                end
                OccFull: begin
                    if (out_fire) begin
                        main_load  = 1'b1;
                        main_d     = skid_data;
                        skid_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_d),
        .data_o  (main_data),
        .valid_o (main_v)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data_i),
        .data_o  (skid_data),
        .valid_o (skid_v)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a two-deep FIFO model plus directed and random traffic.
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic [1:0]    count_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: payloads currently held by the stage, oldest first (capacity 2).
    logic [DW-1:0] sb_q[$];
    logic          pend = 1'b0;
    logic [DW-1:0] pend_data = '0;

    pipe_skid_stage #(
        .DATA_W (DW),
        .BUBBLE (INST_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge, from the stage's rules and the model's own occupancy.
    always @(posedge clk) begin
        int  sz;
        logic mv, mr;
        sz = sb_q.size();
        mv = (sz > 0);
        mr = (sz < 2);
        if (pend) begin
            chk("hold_valid", 32'(in_valid_i), 32'd1);
            chk("hold_data", in_data_i, pend_data);
        end
        if (!rst || flush_i) begin
            sb_q.delete();
        end else begin
            if (mv && out_ready_i) void'(sb_q.pop_front());
            if (in_valid_i && mr) sb_q.push_back(in_data_i);
        end
        pend      = rst && !flush_i && in_valid_i && !mr;
        pend_data = in_data_i;
    end

    // Monitor: compare the presented outputs against the model between edges.
    always @(negedge clk) begin
        int sz;
        sz = sb_q.size();
        chk("count", 32'(count_o), 32'(sz));
        chk("in_ready", 32'(in_ready_o), 32'(sz < 2));
        chk("out_valid", 32'(out_valid_o), 32'(sz > 0));
        if (sz > 0) chk("out_data", out_data_o, sb_q[0]);
        else        chk("bubble", out_data_o, INST_NOP);
    end

    // Drive one cycle's inputs, probe that in_ready_o ignores out_ready_i, then move past the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        logic ir;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        #2;
        ir = in_ready_o;
        out_ready_i = ~r;
        #1;
        chk("ready_comb", 32'(in_ready_o), 32'(ir));
        out_ready_i = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          v, r, f;
        logic [DW-1:0] d;

        // Reset then idle.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_data", out_data_o, 32'h13);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);

        // Back-to-back stream with downstream ready: one-cycle latency, count stays 1.
        step(1'b1, 32'hA1, 1'b1, 1'b0);
        chk("a1", out_data_o, 32'hA1);
        chk("a1_cnt", 32'(count_o), 32'd1);
        step(1'b1, 32'hA2, 1'b1, 1'b0);
        chk("a2", out_data_o, 32'hA2);
        step(1'b1, 32'hA3, 1'b1, 1'b0);
        chk("a3", out_data_o, 32'hA3);
        chk("a3_cnt", 32'(count_o), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("a_drain", 32'(count_o), 32'd0);

        // Backpressure absorbed by the skid entry.
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 32'hB2, 1'b0, 1'b0);
        chk("b_full", 32'(count_o), 32'd2);
        chk("b_nready", 32'(in_ready_o), 32'd0);
        step(1'b1, 32'hB3, 1'b0, 1'b0);
        chk("b_hold_cnt", 32'(count_o), 32'd2);
        chk("b_hold_head", out_data_o, 32'hB1);
        step(1'b1, 32'hB3, 1'b1, 1'b0);
        chk("b_second", out_data_o, 32'hB2);
        step(1'b1, 32'hB3, 1'b1, 1'b0);
        chk("b_third", out_data_o, 32'hB3);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush from FULL drops both entries and the offered payload.
        step(1'b1, 32'hC1, 1'b0, 1'b0);
        step(1'b1, 32'hC2, 1'b0, 1'b0);
        step(1'b1, 32'hC3, 1'b0, 1'b1);
        chk("fl_cnt", 32'(count_o), 32'd0);
        chk("fl_data", out_data_o, INST_NOP);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fl_nodeliver", 32'(out_valid_o), 32'd0);

        // Reset in the middle of a stream, in ONE.
        step(1'b1, 32'hD1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 32'hD2, 1'b1, 1'b0);
        chk("mr_valid", 32'(out_valid_o), 32'd0);
        chk("mr_data", out_data_o, INST_NOP);
        chk("mr_ready", 32'(in_ready_o), 32'd1);
        chk("mr_cnt", 32'(count_o), 32'd0);
        rst = 1'b1;
        step(1'b1, 32'hE1, 1'b1, 1'b0);
        chk("mr_first", out_data_o, 32'hE1);
        chk("mr_first_v", 32'(out_valid_o), 32'd1);

        // Random valid/ready/flush/reset traffic; an unaccepted offer is held stable.
        for (int i = 0; i < 10000; i++) begin
            if (pend) begin
                v = 1'b1;
                d = in_data_i;
            end else begin
                v = ($urandom_range(9) < 7);
                d = $urandom;
            end
            r   = ($urandom_range(9) < 6);
            f   = ($urandom_range(63) == 0);
            rst = ($urandom_range(499) != 0);
            step(v, d, r, f);
        end

        // Drain and confirm nothing is left behind.
        rst = 1'b1;
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_sb", 32'(sb_q.size()), 32'd0);
        chk("drain_cnt", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline-stage register for the RV64 core, the successor to the fixed-field stall/flush stage registers between IF/ID/EX/MEM. It carries an opaque payload of configurable width under a valid/ready handshake and buffers one extra entry (skid), so `in_ready_o` comes straight from a flop and backpressure does not form a combinational path through the pipeline. Flush inserts a bubble, and an empty stage presents a configurable bubble payload, for example a NOP instruction.

## Interface
- `DATA_W`, default 64: payload width in bits. Legal range is 1 to 512.
- `BUBBLE`, default `{DATA_W{1'b0}}`: payload presented on `out_data_o` whenever the stage is empty. Also loaded on reset and on flush.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst` input, 1 bit: synchronous reset, active-low.
- `flush_i` input, 1 bit: kills all held entries. Highest priority after reset.
- `in_valid_i` input, 1 bit: the upstream stage offers a payload.
- `in_ready_o` output, 1 bit: the stage can accept a payload. Registered.
- `in_data_i` input, `DATA_W` bits: upstream payload.
- `out_valid_o` output, 1 bit: the main entry holds a valid payload.
- `out_ready_i` input, 1 bit: the downstream stage accepts the payload.
- `out_data_o` output, `DATA_W` bits: the main-entry payload, or `BUBBLE` when empty.
- `count_o` output, 2 bits: occupancy, 0 to 2.

## Operation
- Input fire: `in_valid_i && in_ready_o`.
- Output fire: `out_valid_o && out_ready_i`.
- Storage is two entries:
  - main: drives the outputs.
  - skid: holds one overflow payload.
- Three states, encoded by occupancy.
- EMPTY (count 0):
  - `in_ready_o` = 1, `out_valid_o` = 0, `out_data_o` = `BUBBLE`.
  - On input fire, main ← `in_data_i` and the state goes to ONE.
- ONE (count 1):
  - `in_ready_o` = 1.
  - Input fire and output fire together: main ← `in_data_i`, stay in ONE.
  - Input fire only: skid ← `in_data_i`, go to FULL.
  - Output fire only: main ← `BUBBLE`, go to EMPTY.
  - Neither: hold.
- FULL (count 2):
  - `in_ready_o` = 0, so any offered input is not taken.
  - Output fire: main ← skid, skid ← `BUBBLE`, go to ONE.
  - Otherwise hold.
- Order is strictly FIFO: a skid payload always leaves before any later payload.
- Flush (`flush_i` = 1 while `rst` = 1):
  - Next state is EMPTY.
  - Both entries are loaded with `BUBBLE`.
  - A payload offered in the flush cycle is dropped, even if `in_ready_o` was 1.
  - An output fire in the same cycle is treated as taken by downstream. Downstream must apply its own flush if needed.
- Reset (`rst` = 0 at an edge):
  - Same effect as flush, and overrides everything else.
  - Reset arriving in FULL discards both payloads.
- No payload is ever duplicated or lost except through flush or reset.

## Timing
- Reset values:
  - `in_ready_o` = 1
  - `out_valid_o` = 0
  - `out_data_o` = `BUBBLE`
  - `count_o` = 0
- Latency: a payload accepted at edge N is on `out_data_o` with `out_valid_o` = 1 after edge N (1 cycle) when the stage was EMPTY, or ONE with an output fire.
- Throughput: one payload per cycle while `out_ready_i` stays at 1.
- Sources of each output:
  - `in_ready_o` is purely a flop: `!skid_valid`. It does not depend on `out_ready_i` in the same cycle.
  - `out_valid_o` and `out_data_o` come from flops only.
- Backpressure:
  - A ready drop on `out_ready_i` is absorbed by the skid entry.
  - `in_ready_o` falls one edge later.
  - Upstream must hold `in_valid_i` and `in_data_i` stable while `in_ready_o` = 0. A bench assertion checks this.
- `count_o` is updated on the same edge as the entries.

## Structure
- Shared defines: `INST_NOP` (32'h00000013) is the `BUBBLE` for instruction-carrying instances. No new package types are required.
- One sub-module, `pipe_entry`:
  - Contents: a `DATA_W`-bit payload flop plus a valid flop.
  - Controls: `load` (takes D), `clear` (takes `BUBBLE`, valid = 0), and reset.
  - Instantiated twice, as main and skid.
- The top level holds only the next-state and steering logic.
- Target size is about 150 to 220 lines of RTL in total.

## Test plan
- Reset then idle, with `DATA_W` = 32 and `BUBBLE` = 32'h13 → `out_data_o` = 32'h13, `out_valid_o` = 0, `in_ready_o` = 1, `count_o` = 0.
- Stream 0xA1, 0xA2, 0xA3 on back-to-back cycles with `out_ready_i` = 1 → outputs 0xA1, 0xA2, 0xA3 on consecutive cycles, 1-cycle latency, `count_o` = 1 throughout.
- Hold `out_ready_i` = 0 and offer 0xB1, 0xB2, 0xB3 → 0xB1 and 0xB2 accepted, `count_o` = 2, `in_ready_o` = 0 from the next edge, 0xB3 held upstream. Then raise `out_ready_i` → 0xB1, 0xB2, 0xB3 arrive in order.
- In FULL with 0xC1/0xC2, assert `flush_i` for one cycle while offering 0xC3 → next cycle `count_o` = 0, `out_data_o` = `BUBBLE`, 0xC3 is not delivered.
- Drive `rst` = 0 mid-stream in the ONE state → next edge gives the reset values, and after release the first new payload appears after 1 cycle.
- Random valid/ready toggling over 10k cycles against a scoreboard → in-order, no loss or duplication, `in_ready_o` never depends combinationally on `out_ready_i`.
